frame_stream_tx: RTL and testbench

FRAME_STREAM_TX -- requirements
Module: frame_stream_tx

---
 rtl/frame_stream_tx.sv | 182 ++++++++++++++++++
 tb/tb_frame_stream_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_stream_tx.sv
// frame_stream_tx: replays a frame buffer as a camera-style byte stream
// (PCLK / VSYNC / HREF / D), fetching bytes from a synchronous frame RAM.
module frame_stream_tx #(
    parameter int CLK_DIV    = 5,
    parameter int LINE_BYTES = 160,
    parameter int LINES      = 120,
    parameter int H_BLANK    = 16,
    parameter int VS_LINES   = 3,
    parameter int V_BACK     = 17,
    parameter int V_FRONT    = 10
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_Enable,
    input  logic [7:0]  i_RAM_Data,
    output logic [14:0] o_RAM_Adress,
    output logic        o_PLK,
    output logic        o_VS,
    output logic        o_HS,
    output logic [7:0]  o_D,
    output logic        o_Busy,
    output logic        o_Frame_Done
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VSYNC  = 3'd1;
    localparam logic [2:0] S_VBACK  = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_HBLANK = 3'd4;
    localparam logic [2:0] S_VFRONT = 3'd5;

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [15:0] C_LINE_LAST  = 16'(LINE_BYTES + H_BLANK - 1);
    localparam logic [15:0] C_ACT_LAST   = 16'(LINE_BYTES - 1);
    localparam logic [15:0] C_HB_LAST    = 16'(H_BLANK - 1);
    localparam logic [15:0] C_LINES_LAST = 16'(LINES - 1);
    localparam logic [15:0] C_VS_LAST    = 16'(VS_LINES - 1);
    localparam logic [15:0] C_VB_LAST    = 16'(V_BACK - 1);
    localparam logic [15:0] C_VF_LAST    = 16'(V_FRONT - 1);
    localparam logic [14:0] C_ADDR_LAST  = 15'(LINE_BYTES * LINES - 1);

    generate
        if (LINE_BYTES * LINES > 32768) begin : g_size_check
            $error("frame_stream_tx: LINE_BYTES*LINES exceeds the 32768-byte frame RAM");
        end
    endgenerate

    logic [DIV_W-1:0] r_div;
    logic             r_plk;
    logic [2:0]       r_state;
    logic [15:0]      r_cnt;
    logic [15:0]      r_line;
    logic             r_vs;
    logic             r_hs;
    logic [7:0]       r_d;
    logic [14:0]      r_addr;
    logic             r_done;

    logic             w_tick;
    logic [2:0]       w_next_state;
    logic [15:0]      w_next_cnt;
    logic [15:0]      w_next_line;
    logic             w_frame_end;

    // Ticks fall on the PCLK falling edge so outputs settle half a period before each rising edge.
    assign w_tick = (r_div == C_DIV_LAST) && r_plk;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_div <= '0;
            r_plk <= 1'b0;
        end else if (r_div == C_DIV_LAST) begin
            r_div <= '0;
            r_plk <= ~r_plk;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt + 16'd1;
        w_next_line  = r_line;
        w_frame_end  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next_cnt  = '0;
                w_next_line = '0;
                if (i_Enable) w_next_state = S_VSYNC;
            end
            S_VSYNC: begin
                if (r_cnt == C_LINE_LAST) begin
                    w_next_cnt  = '0;
                    w_next_line = r_line + 16'd1;
                    if (r_line == C_VS_LAST) begin
                        w_next_line  = '0;
                        w_next_state = (V_BACK != 0) ? S_VBACK : S_ACTIVE;
                    end
                end
            end
            S_VBACK: begin
                if (r_cnt == C_LINE_LAST) begin
                    w_next_cnt  = '0;
                    w_next_line = r_line + 16'd1;
                    if (r_line == C_VB_LAST) begin
                        w_next_line  = '0;
                        w_next_state = S_ACTIVE;
                    end
                end
            end
            S_ACTIVE, S_HBLANK: begin
                if ((r_state == S_ACTIVE && r_cnt == C_ACT_LAST) ||
                    (r_state == S_HBLANK && r_cnt == C_HB_LAST)) begin
                    w_next_cnt = '0;
                    if (r_state == S_ACTIVE && H_BLANK != 0) begin
                        w_next_state = S_HBLANK;
                    end else if (r_line == C_LINES_LAST) begin
                        w_next_line = '0;
                        if (V_FRONT != 0) w_next_state = S_VFRONT;
                        else              w_frame_end  = 1'b1;
                    end else begin
                        w_next_line  = r_line + 16'd1;
                        w_next_state = S_ACTIVE;
                    end
                end
            end
            S_VFRONT: begin
                if (r_cnt == C_LINE_LAST) begin
                    w_next_cnt  = '0;
                    w_next_line = r_line + 16'd1;
                    if (r_line == C_VF_LAST) w_frame_end = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
        // Enable is only honoured here, so a frame in flight always completes.
        if (w_frame_end) begin
            w_next_state = i_Enable ? S_VSYNC : S_IDLE;
            w_next_cnt   = '0;
            w_next_line  = '0;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_line  <= '0;
            r_vs    <= 1'b0;
            r_hs    <= 1'b0;
            r_d     <= '0;
            r_addr  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_tick && w_frame_end;
            if (w_tick) begin
                r_state <= w_next_state;
                r_cnt   <= w_next_cnt;
                r_line  <= w_next_line;
                r_vs    <= (w_next_state == S_VSYNC);
                r_hs    <= (w_next_state == S_ACTIVE);
                if (w_next_state == S_ACTIVE) begin
                    r_d <= i_RAM_Data;
                    // Hold on the final byte so the address never leaves the frame.
                    if (r_addr != C_ADDR_LAST) r_addr <= r_addr + 15'd1;
                end else begin
                    r_d <= '0;
                    if (w_frame_end || r_state == S_IDLE) r_addr <= '0;
                end
            end
        end
    end

    assign o_PLK        = r_plk;
    assign o_VS         = r_vs;
    assign o_HS         = r_hs;
    assign o_D          = r_d;
    assign o_RAM_Adress = r_addr;
    assign o_Busy       = (r_state != S_IDLE);
    assign o_Frame_Done = r_done;

endmodule

// File: tb/tb_frame_stream_tx.sv
// Bench for frame_stream_tx: small frame geometry, RAM[a] = a[7:0] + 0x10,
// per-PCLK sync profile table plus a byte scoreboard.
module tb_frame_stream_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [7:0]  ram_q = 8'h00;
    logic [14:0] o_RAM_Adress;
    logic        o_PLK, o_VS, o_HS, o_Busy, o_Frame_Done;
    logic [7:0]  o_D;

    frame_stream_tx #(
        .CLK_DIV(2), .LINE_BYTES(4), .LINES(3), .H_BLANK(2),
        .VS_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) dut (
        .i_Clk(clk),
        .i_Reset(rst),
        .i_Enable(en),
        .i_RAM_Data(ram_q),
        .o_RAM_Adress(o_RAM_Adress),
        .o_PLK(o_PLK),
        .o_VS(o_VS),
        .o_HS(o_HS),
        .o_D(o_D),
        .o_Busy(o_Busy),
        .o_Frame_Done(o_Frame_Done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_q <= o_RAM_Adress[7:0] + 8'h10;

    typedef struct {
        string name;
        int    len;
        logic  vs;
        logic  hs;
    } seg_t;
    seg_t prof[9];

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int vs_rise_cyc = 0;
    logic [7:0] exp_q[$];
    logic [1:0] elog[$];
    logic prev_plk = 1'b0;
    logic prev_vs  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        nchk++;
        nerr++;
        $display("FAIL %s: got=timeout expected=event", nm);
    endtask

    task automatic push_frame();
        for (int a = 0; a < 12; a++) begin
            logic [7:0] v;
            v = 8'(a) + 8'h10;
            exp_q.push_back(v);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_plk"},  int'(o_PLK), 0);
        chk({tag, "_vs"},   int'(o_VS), 0);
        chk({tag, "_hs"},   int'(o_HS), 0);
        chk({tag, "_d"},    int'(o_D), 0);
        chk({tag, "_addr"}, int'(o_RAM_Adress), 0);
        chk({tag, "_busy"}, int'(o_Busy), 0);
        chk({tag, "_done"}, int'(o_Frame_Done), 0);
    endtask

    task automatic wait_done(input string nm, output int t);
        int k;
        t = -1;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (o_Frame_Done) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) fail_now({"timeout_", nm});
    endtask

    task automatic wait_hs_rise(input string nm);
        logic p;
        logic hit;
        p = o_HS;
        hit = 1'b0;
        for (int k = 0; k < 400 && !hit; k++) begin
            @(negedge clk);
            if (o_HS && !p) hit = 1'b1;
            p = o_HS;
        end
        if (!hit) fail_now({"timeout_", nm});
    endtask

    // Live monitor: one sample per PCLK rising edge, taken on the i_Clk falling edge.
    always @(negedge clk) begin
        if (o_VS && !prev_vs) vs_rise_cyc = cyc;
        if (o_PLK && !prev_plk) begin
            elog.push_back({o_VS, o_HS});
            if (o_HS) begin
                if (exp_q.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL unexpected_byte: got=%0h expected=none", o_D);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk("byte", int'(o_D), int'(e));
                end
                chk("addr_range", int'(o_RAM_Adress <= 15'd11), 1);
            end else begin
                chk("d_outside_active", int'(o_D), 0);
            end
        end
        prev_plk = o_PLK;
        prev_vs  = o_VS;
    end

    initial begin
        int t_done;
        int st;
        int idx;
        int bad;
        logic hit;

        prof[0] = '{"seg_vsync",  6, 1'b1, 1'b0};
        prof[1] = '{"seg_vback",  6, 1'b0, 1'b0};
        prof[2] = '{"seg_line0",  4, 1'b0, 1'b1};
        prof[3] = '{"seg_hb0",    2, 1'b0, 1'b0};
        prof[4] = '{"seg_line1",  4, 1'b0, 1'b1};
        prof[5] = '{"seg_hb1",    2, 1'b0, 1'b0};
        prof[6] = '{"seg_line2",  4, 1'b0, 1'b1};
        prof[7] = '{"seg_hb2",    2, 1'b0, 1'b0};
        prof[8] = '{"seg_vfront", 6, 1'b0, 1'b0};

        // Reset state, then free-running PCLK with enable low
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("plk_div", int'(o_PLK), (k >> 1) & 1);
        end
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_VS || o_HS || o_Busy || o_D != 8'h00) bad = 1;
        end
        chk("idle_quiet", bad, 0);

        // Frame 1
        elog.delete();
        push_frame();
        en = 1'b1;
        wait_done("frame1", t_done);
        if (t_done >= 0) chk("frame_len_clk", t_done - vs_rise_cyc, 144);
        chk("frame1_bytes_consumed", exp_q.size(), 0);
        st = -1;
        for (int i = 0; i < elog.size(); i++)
            if (elog[i][1] && st < 0) st = i;
        chk("vs_found", int'(st >= 0), 1);
        if (st >= 0) begin
            idx = st;
            for (int s = 0; s < 9; s++) begin
                bad = 0;
                for (int j = 0; j < prof[s].len; j++) begin
                    if (idx >= elog.size() || elog[idx] != {prof[s].vs, prof[s].hs}) bad = 1;
                    idx++;
                end
                chk(prof[s].name, bad, 0);
            end
        end
        push_frame();
        @(negedge clk);
        chk("done_single_cycle", int'(o_Frame_Done), 0);

        // Frame 2 back-to-back; drop enable in the second line window
        wait_hs_rise("frame2_line0");
        wait_hs_rise("frame2_line1");
        en = 1'b0;
        wait_done("frame2", t_done);
        chk("frame2_bytes_consumed", exp_q.size(), 0);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_Busy || o_VS || o_HS) bad = 1;
        end
        chk("idle_after_drop", bad, 0);
        chk("busy_after_drop", int'(o_Busy), 0);

        // Frame 3 aborted by reset mid-line, then a clean frame
        push_frame();
        en = 1'b1;
        wait_hs_rise("frame3_line0");
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        repeat (3) @(negedge clk);
        push_frame();
        rst = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 50 && !hit; k++) begin
            @(negedge clk);
            if (o_Busy) hit = 1'b1;
        end
        if (!hit) fail_now("timeout_busy_after_reset");
        else chk("restart_in_vsync", int'(o_VS), 1);
        en = 1'b0;
        wait_done("frame4", t_done);
        chk("frame4_bytes_consumed", exp_q.size(), 0);
        repeat (10) @(negedge clk);
        chk("busy_final", int'(o_Busy), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
